// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite animation sequencer.
package sprite_pkg;
    localparam int DEF_SPRITE_W       = 28;
    localparam int DEF_SPRITE_H       = 42;
    localparam int DEF_NUM_FRAMES     = 4;
    localparam int DEF_FRAME_TICKS    = 6;
    localparam int DEF_COOLDOWN_TICKS = 10;

    localparam int FRAME_WORDS = DEF_SPRITE_W * DEF_SPRITE_H;
    localparam int ADDR_W      = 19;
    localparam int PIX_W       = 5;

    localparam logic [PIX_W-1:0] TRANSPARENT_IDX = 5'd0;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        PLAY     = 2'd1,
        COOLDOWN = 2'd2
    } anim_state_t;
endpackage

// File: rtl/sprite_anim_sequencer_if.sv
// Sprite ROM read bus: registered address out, synchronous-read data back.
interface sprite_anim_sequencer_if;
    import sprite_pkg::*;

    logic [ADDR_W-1:0] rom_addr;
    logic [PIX_W-1:0]  rom_data;

    modport master (output rom_addr, input rom_data);
    modport slave  (input rom_addr, output rom_data);
endinterface

// File: rtl/sprite_addr_pipe.sv
// Three-stage pixel pipeline: draw position -> ROM address -> ROM data -> pixel_on/pixel_idx.
module sprite_addr_pipe
    import sprite_pkg::*;
#(
    parameter int SPRITE_W      = DEF_SPRITE_W,
    parameter int SPRITE_H      = DEF_SPRITE_H,
    parameter int FI_W          = 2,
    parameter int FRAME_WORDS_P = FRAME_WORDS
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic [FI_W-1:0]         frame_idx,
    input  logic                    mirror,
    input  logic [9:0]              DrawX,
    input  logic [9:0]              DrawY,
    input  logic [9:0]              sprite_x,
    input  logic [9:0]              sprite_y,
    sprite_anim_sequencer_if.master rom_bus,
    output logic                    pixel_on,
    output logic [PIX_W-1:0]        pixel_idx
);
    localparam int STAGES = 2;

    logic [9:0]        col, row, col_eff;
    logic              in_box;
    logic [ADDR_W-1:0] addr;
    logic [STAGES:1]   vld_pipe;

    // Offsets left of / above the sprite wrap to large values and fail the box test.
    always_comb begin
        col     = DrawX - sprite_x;
        row     = DrawY - sprite_y;
        in_box  = (col < 10'(SPRITE_W)) && (row < 10'(SPRITE_H));
        col_eff = mirror ? (10'(SPRITE_W - 1) - col) : col;
        addr    = ADDR_W'(frame_idx) * ADDR_W'(FRAME_WORDS_P)
                + ADDR_W'(row) * ADDR_W'(SPRITE_W)
                + ADDR_W'(col_eff);
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            rom_bus.rom_addr <= '0;
            vld_pipe         <= '0;
            pixel_on         <= 1'b0;
            pixel_idx        <= TRANSPARENT_IDX;
        end else begin
            rom_bus.rom_addr <= in_box ? addr : '0;
            vld_pipe         <= {vld_pipe[STAGES-1:1], in_box};
            pixel_on         <= vld_pipe[STAGES] && (rom_bus.rom_data != TRANSPARENT_IDX);
            pixel_idx        <= vld_pipe[STAGES] ? rom_bus.rom_data : TRANSPARENT_IDX;
        end
    end
endmodule

// File: rtl/sprite_anim_sequencer.sv
// Attack animation sequencer: frame/cooldown FSM on frame_tick plus sprite ROM address pipeline.
// Optional build macro SPRITE_MIRROR_EN enables horizontal mirroring from facing_right.
module sprite_anim_sequencer
    import sprite_pkg::*;
#(
    parameter int SPRITE_W       = DEF_SPRITE_W,
    parameter int SPRITE_H       = DEF_SPRITE_H,
    parameter int NUM_FRAMES     = DEF_NUM_FRAMES,
    parameter int FRAME_TICKS    = DEF_FRAME_TICKS,
    parameter int COOLDOWN_TICKS = DEF_COOLDOWN_TICKS
) (
    input  logic                          Clk,
    input  logic                          Reset,
    input  logic                          frame_tick,
    input  logic                          attack_req,
    input  logic                          facing_right,
    input  logic [9:0]                    DrawX,
    input  logic [9:0]                    DrawY,
    input  logic [9:0]                    sprite_x,
    input  logic [9:0]                    sprite_y,
    sprite_anim_sequencer_if.master       rom_bus,
    output logic                          pixel_on,
    output logic [PIX_W-1:0]              pixel_idx,
    output logic                          busy,
    output logic [$clog2(NUM_FRAMES)-1:0] frame_idx,
    output logic                          anim_done
);
    localparam int FI_W    = $clog2(NUM_FRAMES);
    localparam int MAX_TK  = (FRAME_TICKS > COOLDOWN_TICKS) ? FRAME_TICKS : COOLDOWN_TICKS;
    localparam int CNT_W   = $clog2(MAX_TK + 1);
    localparam logic [CNT_W-1:0] FT_LAST = CNT_W'(FRAME_TICKS - 1);
    localparam logic [CNT_W-1:0] CD_LAST = CNT_W'(COOLDOWN_TICKS - 1);
    localparam logic [FI_W-1:0]  FR_LAST = FI_W'(NUM_FRAMES - 1);

`ifdef SPRITE_MIRROR_EN
    localparam bit MIRROR_EN = 1'b1;
`else
    localparam bit MIRROR_EN = 1'b0;
`endif

    anim_state_t      state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic [FI_W-1:0]  frame_n;
    logic             done_n, busy_n;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state     <= IDLE;
            cnt       <= '0;
            frame_idx <= '0;
            anim_done <= 1'b0;
            busy      <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            frame_idx <= frame_n;
            anim_done <= done_n;
            busy      <= busy_n;
        end
    end

    // The tick counter is shared: frame hold time in PLAY, cooldown length in COOLDOWN.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        frame_n = frame_idx;
        done_n  = 1'b0;
        case (state)
            IDLE: begin
                if (attack_req) begin
                    state_n = PLAY;
                    cnt_n   = '0;
                    frame_n = '0;
                end
            end
            PLAY: begin
                if (frame_tick) begin
                    if (cnt == FT_LAST) begin
                        cnt_n = '0;
                        if (frame_idx == FR_LAST) begin
                            state_n = COOLDOWN;
                            done_n  = 1'b1;
                            frame_n = '0;
                        end else begin
                            frame_n = frame_idx + 1'b1;
                        end
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
            end
            COOLDOWN: begin
                if (frame_tick) begin
                    if (cnt == CD_LAST) begin
                        cnt_n   = '0;
                        state_n = IDLE;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
        busy_n = (state_n == PLAY) || (state_n == COOLDOWN);
    end

    sprite_addr_pipe #(
        .SPRITE_W      (SPRITE_W),
        .SPRITE_H      (SPRITE_H),
        .FI_W          (FI_W),
        .FRAME_WORDS_P (SPRITE_W * SPRITE_H)
    ) u_pipe (
        .Clk       (Clk),
        .Reset     (Reset),
        .frame_idx (frame_idx),
        .mirror    (MIRROR_EN && facing_right),
        .DrawX     (DrawX),
        .DrawY     (DrawY),
        .sprite_x  (sprite_x),
        .sprite_y  (sprite_y),
        .rom_bus   (rom_bus),
        .pixel_on  (pixel_on),
        .pixel_idx (pixel_idx)
    );
endmodule

// File: doc/sprite_anim_sequencer.md
Name: sprite_anim_sequencer

Overview:
- Drives read_address of a single-port, synchronous-read sprite ROM holding NUM_FRAMES attack-animation frames stored back to back. Entries are 5-bit palette indices; index 0 is transparent.
- Sequences frames on vertical-blank ticks after an attack request.
- Maps the VGA draw position into the current frame's ROM address and re-aligns the returned data into a pixel_on / pixel_idx pair for the colour mapper.

Parameters:
- SPRITE_W, 28, sprite width in pixels
- SPRITE_H, 42, sprite height in pixels
- NUM_FRAMES, 4, frames in the animation strip
- FRAME_TICKS, 6, frame_tick pulses each frame is held
- COOLDOWN_TICKS, 10, frame_tick pulses after the last frame before a new attack is accepted

Ports:
- Clk  in  1  system clock
- Reset  in  1  synchronous, active-high reset
- frame_tick  in  1  single-cycle pulse, once per video frame
- attack_req  in  1  level or pulse; starts an animation when sampled high in IDLE
- facing_right  in  1  mirror request (used only with the optional feature)
- DrawX  in  10  current pixel column
- DrawY  in  10  current pixel row
- sprite_x  in  10  sprite top-left column
- sprite_y  in  10  sprite top-left row
- rom_addr  out  19  registered read address to the sprite ROM
- rom_data  in  5  ROM data_Out, valid one clock after rom_addr is sampled
- pixel_on  out  1  current pipelined pixel is opaque sprite
- pixel_idx  out  5  palette index for that pixel
- busy  out  1  high in PLAY or COOLDOWN
- frame_idx  out  2  current frame number, width clog2(NUM_FRAMES)
- anim_done  out  1  one-cycle pulse on the PLAY->COOLDOWN transition

Behaviour:
- Reset values: all outputs 0; state IDLE; tick counter 0; pipeline valid bits 0.
- States:
  - IDLE: attack_req=1 -> PLAY with frame_idx=0 and tick counter 0. A frame_tick in the same cycle is not counted.
  - PLAY: each frame_tick increments the tick counter. When the counter reaches FRAME_TICKS-1 together with a tick, the counter clears and frame_idx increments.
    - On the last frame, that event moves to COOLDOWN, asserts anim_done for 1 cycle and resets frame_idx to 0.
    - attack_req is ignored in PLAY.
  - COOLDOWN: counts COOLDOWN_TICKS frame_ticks, then -> IDLE. attack_req is ignored.
- busy is a registered decode: 1 exactly while the state is PLAY or COOLDOWN.
- Reset during any state returns to IDLE next edge and flushes the pixel pipeline.
- Pixel pipeline, 3 clocks from DrawX/DrawY sampling to pixel_on/pixel_idx:
  - Stage 1, edge k:
    - col = DrawX - sprite_x, row = DrawY - sprite_y, both 10-bit unsigned with wrap. Negative offsets wrap large and fall out of the box.
    - in_box = (col < SPRITE_W) && (row < SPRITE_H).
    - rom_addr <= frame_idx*SPRITE_W*SPRITE_H + row*SPRITE_W + col when in_box; otherwise rom_addr <= 0.
    - v1 <= in_box.
  - Stage 2, edge k+1: the ROM registers data; v2 <= v1.
  - Stage 3, edge k+2: pixel_on <= v2 && (rom_data != 0); pixel_idx <= v2 ? rom_data : 0.
- Arithmetic is computed at 19 bits with no overflow. The maximum address is NUM_FRAMES*W*H-1 = 4703.
- frame_idx may change mid-scanline. Tearing is accepted; the change becomes visible at the next stage-1 sample.
- The sprite is drawn in every state. IDLE shows frame 0.

Optional Feature:
- SPRITE_MIRROR_EN defined: when facing_right=1, stage 1 uses col' = SPRITE_W-1-col in the address. The in_box test is unchanged.
- Not defined: facing_right is ignored; the ROM image is always drawn unmirrored.

Decomposition:
- Package sprite_pkg: typedef enum {IDLE, PLAY, COOLDOWN} anim_state_t; localparams FRAME_WORDS = SPRITE_W*SPRITE_H and ADDR_W = 19; the TRANSPARENT_IDX = 0 constant.
- One natural sub-module: sprite_addr_pipe, holding the stage 1–3 address/valid pipeline. The FSM and counters stay in the top module.

Test Plan:
- Reset mid-PLAY (frame 2) -> next edge: busy=0, frame_idx=0, rom_addr=0, pixel_on=0; anim_done never pulses.
- IDLE, attack_req pulse, then 24 frame_ticks -> frame_idx steps 0,1,2,3 every 6 ticks. On tick 24: anim_done=1 for 1 cycle, busy stays 1. After 10 more ticks busy=0.
- attack_req held high during PLAY and COOLDOWN -> no restart; a new PLAY starts only on the first cycle back in IDLE.
- sprite_x=100, sprite_y=50, frame_idx=1, DrawX=103, DrawY=52:
  - rom_addr = 1176 + 2*28 + 3 = 1235 one edge later.
  - With rom_data=7 the next cycle, pixel_on=1 and pixel_idx=7 three edges after sampling.
- Boundary and transparency:
  - DrawX=127 (col 27) -> in box.
  - DrawX=128 -> pixel_on=0, rom_addr=0.
  - DrawX=99 (col wraps to 1023) -> out of box.
  - rom_data=0 with v2=1 -> pixel_on=0, pixel_idx=0.
- With SPRITE_MIRROR_EN and facing_right=1, col=0, row=0, frame 0 -> rom_addr=27. With facing_right=0 -> rom_addr=0.
